// File: rtl/uart_tx_axil.sv
// AXI-Lite UART transmitter: byte FIFO fed by the write channel, 8N1 serialiser
// with a runtime baud divisor, and status/divisor readback on the read channel.
module uart_tx_axil #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 16,
  parameter bit SIM_PRINT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [15:0] div_sat(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [15:0]   div;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        tx_n, busy;

  logic        wr_err, rd_err;
  logic [31:0] rd_mux, status;

  logic unused_bits;
  assign unused_bits = ^{awaddr[31:4], araddr[31:4], wdata[31:16]};

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign busy   = (state != S_IDLE);
  assign wready = awready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push   = awready && (awaddr[3:0] == 4'h0) && (!full || pop);
  assign status = {16'h0, 8'(count), 5'b0, busy, empty, full};

  always_comb begin
    wr_err = 1'b1;
    case (awaddr[3:0])
      4'h0:    wr_err = full && !pop;
      4'h8:    wr_err = 1'b0;
      default: wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    rd_err = 1'b0;
    case (araddr[3:0])
      4'h0:    rd_mux = 32'h0;
      4'h4:    rd_mux = status;
      4'h8:    rd_mux = {16'h0, div};
      default: rd_err = 1'b1;
    endcase
  end

  // Write channel: one-cycle accept pulse, response held until bready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awready <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      div     <= 16'(CLK_DIV);
    end else begin
      awready <= awvalid && wvalid && !awready && !bvalid;
      if (awready) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? 2'b10 : 2'b00;
        if (awaddr[3:0] == 4'h8) div <= div_sat(wdata[15:0]);
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read channel: data captured on the accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= 32'h0;
    end else begin
      arready <= arvalid && !rvalid && !arready;
      if (arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
        rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata[7:0];
`ifndef SYNTHESIS
      if (SIM_PRINT) $write("%c", wdata[7:0]);
`endif
    end
  end

  // Serialiser: every bit reloads the counter, so a new divisor applies at the next boundary
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          cnt_n   = div - 16'd1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == 16'd0) begin
          state_n = S_DATA;
          cnt_n   = div - 16'd1;
          bit_n   = 3'd0;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = div - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            cnt_n   = div - 16'd1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= sh_n;
  end

endmodule

// File: tb/tb_uart_tx_axil.sv
// Directed bench for uart_tx_axil: register access, frame shape, overflow,
// backpressure and mid-frame reset, each checked against hand-computed values.
module tb_uart_tx_axil;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awready, wready, bvalid, arready, rvalid, tx;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int aw_cyc  = 0;

  uart_tx_axil #(.FIFO_DEPTH(4), .CLK_DIV(4), .SIM_PRINT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    chk("awready/wready pulse", {awready, wready}, 2'b11);
    aw_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input int div, input int start_exp, input string nm);
    int   n;
    logic exp_bit;
    n = 0;
    while (tx !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " start cycle"}, 32'(cyc), 32'(start_exp));
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      chk($sformatf("%s bit%0d first", nm, i), {31'b0, tx}, {31'b0, exp_bit});
      repeat (div - 1) @(posedge clk);
      #1;
      chk($sformatf("%s bit%0d last", nm, i), {31'b0, tx}, {31'b0, exp_bit});
      @(posedge clk); #1;
    end
    chk({nm, " idle after frame"}, {31'b0, tx}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, ws;
    int          n, lows, s;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("tx during reset", {31'b0, tx}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset awready", {31'b0, awready}, 32'h0);
    chk("reset wready", {31'b0, wready}, 32'h0);
    chk("reset arready", {31'b0, arready}, 32'h0);
    chk("reset bvalid", {31'b0, bvalid}, 32'h0);
    chk("reset rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset bresp", {30'b0, bresp}, 32'h0);
    chk("reset rresp", {30'b0, rresp}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset tx", {31'b0, tx}, 32'h1);
    axi_read(32'h4, rd, rs);
    chk("reset STATUS", rd, 32'h0000_0002);
    chk("reset STATUS rresp", {30'b0, rs}, 32'h0);
    axi_read(32'h8, rd, rs);
    chk("reset DIV", rd, 32'h4);

    // Single byte at DIV=4
    axi_write(32'h0, 32'h41, ws);
    chk("TXDATA 0x41 bresp", {30'b0, ws}, 32'h0);
    check_frame(8'h41, 4, aw_cyc + 2, "0x41");
    axi_read(32'h4, rd, rs);
    chk("STATUS after frame", rd, 32'h0000_0002);

    // Divisor register, zero stored as one, then 3-cycle bits
    axi_write(32'h8, 32'h0, ws);
    chk("DIV write 0 bresp", {30'b0, ws}, 32'h0);
    axi_read(32'h8, rd, rs);
    chk("DIV after write 0", rd, 32'h1);
    axi_write(32'h8, 32'h3, ws);
    axi_read(32'h8, rd, rs);
    chk("DIV after write 3", rd, 32'h3);
    axi_write(32'h0, 32'hA5, ws);
    check_frame(8'hA5, 3, aw_cyc + 2, "0xA5");

    // Overflow with DIV=100
    axi_write(32'h8, 32'd100, ws);
    for (int i = 0; i < 6; i++) begin
      axi_write(32'h0, 32'h30 + 32'(i), ws);
      chk($sformatf("overflow write%0d bresp", i), {30'b0, ws}, (i == 5) ? 32'h2 : 32'h0);
    end
    axi_read(32'h4, rd, rs);
    chk("STATUS full", rd, 32'h0000_0405);
    axi_read(32'h0, rd, rs);
    chk("TXDATA read data", rd, 32'h0);
    chk("TXDATA read rresp", {30'b0, rs}, 32'h0);
    axi_read(32'hC, rd, rs);
    chk("0xC read data", rd, 32'h0);
    chk("0xC read rresp", {30'b0, rs}, 32'h2);
    axi_write(32'h4, 32'h1, ws);
    chk("STATUS write bresp", {30'b0, ws}, 32'h2);

    // Backpressure: SLVERR response held while bready low
    awaddr = 32'hC; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    @(posedge clk); #1;
    awaddr = 32'h8; wdata = 32'd100;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp bvalid c%0d", i), {31'b0, bvalid}, 32'h1);
      chk($sformatf("bp bresp c%0d", i), {30'b0, bresp}, 32'h2);
      chk($sformatf("bp awready c%0d", i), {31'b0, awready}, 32'h0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bp bvalid after handshake", {31'b0, bvalid}, 32'h0);
    chk("bp awready at handshake+1", {31'b0, awready}, 32'h0);
    @(posedge clk); #1;
    chk("bp second accept", {31'b0, awready}, 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp second bvalid", {31'b0, bvalid}, 32'h1);
    chk("bp second bresp", {30'b0, bresp}, 32'h0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // Reset mid-frame during data bit 3
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    axi_write(32'h0, 32'h41, ws);
    s = aw_cyc + 2;
    axi_write(32'h0, 32'h42, ws);
    chk("queued 0x42 bresp", {30'b0, ws}, 32'h0);
    n = 0;
    while (cyc < s + 17 && n < 100) begin @(posedge clk); #1; n++; end
    chk("tx in data bit3", {31'b0, tx}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("tx at async reset", {31'b0, tx}, 32'h1);
    chk("bvalid at reset", {31'b0, bvalid}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h4, rd, rs);
    chk("STATUS after mid-frame reset", rd, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    chk("no frame after reset", 32'(lows), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
